// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_pkg
//  Description : Shared encodings for the cache-to-AXI bridge. Holds the
//                request-type codes, the AXI beat-size codes, the read and
//                write FSM state enums, and a helper that maps a request type
//                to its AXI size.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

    // Request type encodings shared by rd_type and wr_type
    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    // AXI AxSIZE codes (log2 of bytes per beat)
    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Line refills and victims move full 32-bit beats
    function automatic logic [2:0] axi_size(input logic [2:0] req_type);
        case (req_type)
            TYPE_LINE, TYPE_WORD: axi_size = AXI_SIZE_4B;
            TYPE_HALF:            axi_size = AXI_SIZE_2B;
            default:              axi_size = AXI_SIZE_1B;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_write_channel.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_channel
//  Description : Write half of the cache-to-AXI bridge. Latches one write
//                request (line or partial), drives the AW and W channels
//                independently, then waits for the B response.
//  Ports       : clk/rst           clock, async active-low reset
//                wr_*              cache-side write request and ready
//                aw*/w*/b*         AXI4 write channels
//                busy, busy_addr   write outstanding and its latched address
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_write_channel
    import bridge_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_req,
    input  logic [2:0]                wr_type,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [3:0]                wr_wstrb,
    input  logic [32*LINE_BEATS-1:0]  wr_data,
    output logic                      wr_rdy,
    output logic [ADDR_W-1:0]         awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      busy,
    output logic [ADDR_W-1:0]         busy_addr
);

    localparam int OFF_W = $clog2(LINE_BEATS * 4);
    localparam int CNT_W = $clog2(LINE_BEATS);

    wr_state_t                 r_state;
    wr_state_t                 w_next;
    logic                      r_line;
    logic [3:0]                r_wstrb;
    logic [32*LINE_BEATS-1:0]  r_data;
    logic [CNT_W-1:0]          r_wcnt;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_is_last;

    assign w_is_last = !r_line || (r_wcnt == CNT_W'(LINE_BEATS - 1));
    assign w_aw_hs   = (r_state == W_BUSY) && !r_aw_done && awready;
    assign w_w_hs    = (r_state == W_BUSY) && !r_w_done && wready;

    assign awvalid   = (r_state == W_BUSY) && !r_aw_done;
    assign wvalid    = (r_state == W_BUSY) && !r_w_done;
    assign wlast     = wvalid && w_is_last;
    assign wdata     = r_line ? r_data[32*r_wcnt +: 32] : r_data[31:0];
    assign wstrb     = r_line ? 4'hf : r_wstrb;
    assign busy      = (r_state != W_IDLE);
    assign busy_addr = awaddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= W_IDLE;
            awaddr    <= '0;
            awlen     <= '0;
            awsize    <= '0;
            r_line    <= 1'b0;
            r_wstrb   <= '0;
            r_data    <= '0;
            r_wcnt    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == W_IDLE && wr_req) begin
                r_line    <= (wr_type == TYPE_LINE);
                awaddr    <= (wr_type == TYPE_LINE) ? {wr_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : wr_addr;
                awlen     <= (wr_type == TYPE_LINE) ? 8'(LINE_BEATS - 1) : 8'd0;
                awsize    <= axi_size(wr_type);
                r_wstrb   <= wr_wstrb;
                r_data    <= wr_data;
                r_wcnt    <= '0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (w_is_last) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        wr_rdy = 1'b0;
        bready = 1'b0;
        case (r_state)
            W_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) begin
                    w_next = W_BUSY;
                end
            end
            W_BUSY: begin
                // Address and last data beat may finish in either order or together
                if ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && w_is_last))) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cache_axi_bridge
//  Description : Converts dcache refill reads and victim/uncached writes into
//                AXI4 bursts. One read and one write may be outstanding at a
//                time; a read to a line with a pending write is held off until
//                that write's response completes.
//  Ports       : clk/rst           clock, async active-low reset
//                rd_*/ret_*        cache-side read request and returned beats
//                wr_*              cache-side write request
//                ar*/r*            AXI4 read channels
//                aw*/w*/b*         AXI4 write channels
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_bridge
    import bridge_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_req,
    input  logic [2:0]                rd_type,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_rdy,
    output logic                      ret_valid,
    output logic                      ret_last,
    output logic [31:0]               ret_data,
    input  logic                      wr_req,
    input  logic [2:0]                wr_type,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [3:0]                wr_wstrb,
    input  logic [32*LINE_BEATS-1:0]  wr_data,
    output logic                      wr_rdy,
    output logic [ADDR_W-1:0]         araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [31:0]               rdata,
    input  logic                      rvalid,
    input  logic                      rlast,
    output logic                      rready,
    output logic [ADDR_W-1:0]         awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int OFF_W = $clog2(LINE_BEATS * 4);

    rd_state_t          r_rstate;
    rd_state_t          w_rnext;
    logic               w_wr_busy;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic               w_raw_hazard;
    logic               w_rd_accept;

    // Only a latched write blocks reads; a same-cycle write never does
    assign w_raw_hazard = w_wr_busy && (w_wr_addr[ADDR_W-1:OFF_W] == rd_addr[ADDR_W-1:OFF_W]);
    assign w_rd_accept  = (r_rstate == R_IDLE) && rd_req && !w_raw_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            araddr   <= '0;
            arlen    <= '0;
            arsize   <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (w_rd_accept) begin
                araddr <= (rd_type == TYPE_LINE) ? {rd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : rd_addr;
                arlen  <= (rd_type == TYPE_LINE) ? 8'(LINE_BEATS - 1) : 8'd0;
                arsize <= axi_size(rd_type);
            end
        end
    end

    always_comb begin
        w_rnext   = r_rstate;
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        case (r_rstate)
            R_IDLE: begin
                rd_rdy = !w_raw_hazard;
                if (w_rd_accept) begin
                    w_rnext = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_rnext = R_DATA;
                end
            end
            R_DATA: begin
                // Beats pass straight through to the cache without buffering
                rready    = 1'b1;
                ret_valid = rvalid;
                ret_last  = rvalid && rlast;
                ret_data  = rdata;
                if (rvalid && rlast) begin
                    w_rnext = R_IDLE;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    axi_write_channel #(
        .LINE_BEATS (LINE_BEATS),
        .ADDR_W     (ADDR_W)
    ) u_axi_write_channel (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .busy      (w_wr_busy),
        .busy_addr (w_wr_addr)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_axi_bridge
//  Description : Self-checking bench for cache_axi_bridge. Plays the AXI
//                slave with scripted and randomized handshake delays and
//                compares every bridge output against a request-level model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_bridge;

    localparam logic [2:0] T_BYTE = 3'b000;
    localparam logic [2:0] T_HALF = 3'b001;
    localparam logic [2:0] T_WORD = 3'b010;
    localparam logic [2:0] T_LINE = 3'b100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = '0;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_type = '0;
    logic [31:0]  wr_addr = '0;
    logic [3:0]   wr_wstrb = '0;
    logic [127:0] wr_data = '0;
    logic         wr_rdy;
    logic [31:0]  araddr, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic         arvalid, awvalid, wvalid, wlast, rready, bready;
    logic         arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic         rvalid = 1'b0, rlast = 1'b0, bvalid = 1'b0;
    logic [31:0]  rdata = '0;
    logic [3:0]   wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    // ---------------- request-level reference model ----------------
    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [2:0] t);
        return (t == T_LINE) ? (a / 32'd16) * 32'd16 : a;
    endfunction

    function automatic int m_beats(input logic [2:0] t);
        return (t == T_LINE) ? 4 : 1;
    endfunction

    function automatic logic [2:0] m_size(input logic [2:0] t);
        int bytes;
        bytes = (t == T_LINE || t == T_WORD) ? 4 : (t == T_HALF) ? 2 : 1;
        return 3'($clog2(bytes));
    endfunction

    function automatic logic [31:0] m_wbeat(input logic [127:0] d, input logic [2:0] t, input int i);
        logic [127:0] sh;
        sh = (t == T_LINE) ? (d >> (32 * i)) : d;
        return sh[31:0];
    endfunction

    // ---------------- read-side stimulus ----------------
    task automatic rd_request(input logic [31:0] addr, input logic [2:0] typ);
        @(negedge clk);
        rd_req = 1'b1; rd_addr = addr; rd_type = typ;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) $display("FAIL rd_rdy_accept got %b exp 1", rd_rdy); else n_pass++;
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (arvalid !== 1'b1 || araddr !== ea)
                $display("FAIL ar_hold got v=%b a=%h exp v=1 a=%h", arvalid, araddr, ea);
            else n_pass++;
        end
        @(negedge clk);
        arready = 1'b1;
        #1;
        n_checks++; if (arvalid !== 1'b1) $display("FAIL arvalid got %b exp 1", arvalid); else n_pass++;
        n_checks++; if (araddr !== ea) $display("FAIL araddr got %h exp %h", araddr, ea); else n_pass++;
        n_checks++; if (arlen !== el) $display("FAIL arlen got %0d exp %0d", arlen, el); else n_pass++;
        n_checks++; if (arsize !== es) $display("FAIL arsize got %0d exp %0d", arsize, es); else n_pass++;
        @(posedge clk);
        #1 arready = 1'b0;
    endtask

    task automatic r_beats(input int beats, input logic [31:0] base, input int gapmax);
        for (int i = 0; i < beats; i++) begin
            int gap;
            gap = int'($urandom_range(gapmax, 0));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); #1;
                n_checks++;
                if (ret_valid !== 1'b0 || rready !== 1'b1 || arvalid !== 1'b0)
                    $display("FAIL r_gap got ret_valid=%b rready=%b arvalid=%b exp 0 1 0", ret_valid, rready, arvalid);
                else n_pass++;
            end
            @(negedge clk);
            rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == beats - 1);
            #1;
            n_checks++;
            if (ret_valid !== 1'b1 || ret_data !== base + 32'(i))
                $display("FAIL ret_beat%0d got v=%b d=%h exp v=1 d=%h", i, ret_valid, ret_data, base + 32'(i));
            else n_pass++;
            n_checks++;
            if (ret_last !== (i == beats - 1))
                $display("FAIL ret_last%0d got %b exp %b", i, ret_last, (i == beats - 1));
            else n_pass++;
            @(posedge clk);
            #1 rvalid = 1'b0; rlast = 1'b0;
        end
        @(negedge clk); #1;
        n_checks++; if (rd_rdy !== 1'b1) $display("FAIL rd_rdy_after_last got %b exp 1", rd_rdy); else n_pass++;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input int ar_delay,
                           input int gapmax, input logic [31:0] base);
        rd_request(addr, typ);
        ar_phase(m_addr(addr, typ), 8'(m_beats(typ) - 1), m_size(typ), ar_delay);
        r_beats(m_beats(typ), base, gapmax);
    endtask

    // ---------------- write-side stimulus ----------------
    task automatic wr_request(input logic [31:0] addr, input logic [2:0] typ,
                              input logic [3:0] strb, input logic [127:0] data);
        @(negedge clk);
        wr_req = 1'b1; wr_addr = addr; wr_type = typ; wr_wstrb = strb; wr_data = data;
        #1;
        n_checks++; if (wr_rdy !== 1'b1) $display("FAIL wr_rdy_accept got %b exp 1", wr_rdy); else n_pass++;
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    task automatic aw_phase(input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (awvalid !== 1'b1 || awaddr !== ea || wr_rdy !== 1'b0)
                $display("FAIL aw_hold got v=%b a=%h rdy=%b exp v=1 a=%h rdy=0", awvalid, awaddr, wr_rdy, ea);
            else n_pass++;
        end
        @(negedge clk);
        awready = 1'b1;
        #1;
        n_checks++; if (awvalid !== 1'b1) $display("FAIL awvalid got %b exp 1", awvalid); else n_pass++;
        n_checks++; if (awaddr !== ea) $display("FAIL awaddr got %h exp %h", awaddr, ea); else n_pass++;
        n_checks++; if (awlen !== el) $display("FAIL awlen got %0d exp %0d", awlen, el); else n_pass++;
        n_checks++; if (awsize !== es) $display("FAIL awsize got %0d exp %0d", awsize, es); else n_pass++;
        @(posedge clk);
        #1 awready = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] ed, input logic [3:0] es, input logic el, input int gap,
                          input bit with_aw, input logic [31:0] ea);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk); #1;
            n_checks++;
            if (wvalid !== 1'b1 || wdata !== ed)
                $display("FAIL w_hold got v=%b d=%h exp v=1 d=%h", wvalid, wdata, ed);
            else n_pass++;
        end
        @(negedge clk);
        wready = 1'b1;
        awready = with_aw;
        #1;
        n_checks++;
        if (wvalid !== 1'b1 || wdata !== ed)
            $display("FAIL wdata got v=%b d=%h exp v=1 d=%h", wvalid, wdata, ed);
        else n_pass++;
        n_checks++;
        if (wstrb !== es || wlast !== el)
            $display("FAIL wstrb_wlast got %h/%b exp %h/%b", wstrb, wlast, es, el);
        else n_pass++;
        if (with_aw) begin
            n_checks++;
            if (awvalid !== 1'b1 || awaddr !== ea)
                $display("FAIL aw_with_w got v=%b a=%h exp v=1 a=%h", awvalid, awaddr, ea);
            else n_pass++;
        end
        @(posedge clk);
        #1 wready = 1'b0; awready = 1'b0;
    endtask

    task automatic b_phase(input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (bready !== 1'b1 || wr_rdy !== 1'b0 || wvalid !== 1'b0 || awvalid !== 1'b0)
                $display("FAIL b_wait got bready=%b wr_rdy=%b wv=%b awv=%b exp 1 0 0 0", bready, wr_rdy, wvalid, awvalid);
            else n_pass++;
        end
        @(negedge clk);
        bvalid = 1'b1;
        #1;
        n_checks++; if (bready !== 1'b1) $display("FAIL bready got %b exp 1", bready); else n_pass++;
        @(posedge clk);
        #1 bvalid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (wr_rdy !== 1'b1) $display("FAIL wr_rdy_after_b got %b exp 1", wr_rdy); else n_pass++;
    endtask

    // mode 0: AW before W, mode 1: W before AW, mode 2: AW with the last W beat
    task automatic do_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                            input logic [127:0] data, input int mode, input int aw_delay,
                            input int gapmax, input int b_delay);
        logic [31:0] ea;
        logic [3:0]  es;
        int          n;
        ea = m_addr(addr, typ);
        es = (typ == T_LINE) ? 4'hf : strb;
        n  = m_beats(typ);
        wr_request(addr, typ, strb, data);
        if (mode == 0) aw_phase(ea, 8'(n - 1), m_size(typ), aw_delay);
        for (int i = 0; i < n - 1; i++)
            w_beat(m_wbeat(data, typ, i), es, 1'b0, int'($urandom_range(gapmax, 0)), 1'b0, ea);
        if (mode == 2) begin
            for (int i = 0; i < aw_delay; i++) begin
                @(negedge clk); #1;
                n_checks++;
                if (awvalid !== 1'b1 || wvalid !== 1'b1)
                    $display("FAIL aw_w_wait got awv=%b wv=%b exp 1 1", awvalid, wvalid);
                else n_pass++;
            end
        end
        w_beat(m_wbeat(data, typ, n - 1), es, 1'b1, int'($urandom_range(gapmax, 0)), (mode == 2), ea);
        if (mode == 1) aw_phase(ea, 8'(n - 1), m_size(typ), aw_delay);
        b_phase(b_delay);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({rd_rdy, wr_rdy, arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid, ret_last} !== 10'b1100000000)
            $display("FAIL reset_ctrl got %b exp 1100000000",
                     {rd_rdy, wr_rdy, arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid, ret_last});
        else n_pass++;
        n_checks++;
        if ({araddr, awaddr, arlen, awlen, arsize, awsize, wdata, wstrb, ret_data} !== '0)
            $display("FAIL reset_data got %h %h %h %h %h %h %h %h %h exp all 0",
                     araddr, awaddr, arlen, awlen, arsize, awsize, wdata, wstrb, ret_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_line_read();
        do_read(32'h1C00_0038, T_LINE, 2, 2, 32'h0000_00A0);
    endtask

    task automatic test_word_read();
        do_read(32'hBFAF_8004, T_WORD, 5, 0, $urandom);
    endtask

    task automatic test_line_write();
        do_write(32'h0000_1000, T_LINE, 4'h0, 128'h44444444_33333333_22222222_11111111, 1, 3, 1, 2);
    endtask

    task automatic test_byte_write();
        do_write(32'h0000_2003, T_BYTE, 4'b1000, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 1);
    endtask

    task automatic test_raw_hazard();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        wr_request(32'h0000_3000, T_LINE, 4'h0, d);
        aw_phase(32'h0000_3000, 8'd3, 3'd2, 0);
        for (int i = 0; i < 4; i++)
            w_beat(m_wbeat(d, T_LINE, i), 4'hf, (i == 3), 0, 1'b0, 32'h0000_3000);
        // write now waiting on B; same-line read must stall
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 32'h0000_3008; rd_type = T_WORD;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) $display("FAIL raw_block got %b exp 0", rd_rdy); else n_pass++;
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if (rd_rdy !== 1'b0 || arvalid !== 1'b0)
                $display("FAIL raw_hold got rdy=%b arv=%b exp 0 0", rd_rdy, arvalid);
            else n_pass++;
        end
        // different line goes straight through
        @(negedge clk);
        rd_addr = 32'h0000_4000;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) $display("FAIL raw_other_line got %b exp 1", rd_rdy); else n_pass++;
        @(posedge clk);
        #1 rd_req = 1'b0;
        ar_phase(32'h0000_4000, 8'd0, 3'd2, 1);
        r_beats(1, $urandom, 1);
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 32'h0000_3008; rd_type = T_WORD;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) $display("FAIL raw_block2 got %b exp 0", rd_rdy); else n_pass++;
        @(negedge clk);
        bvalid = 1'b1;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b0 || arvalid !== 1'b0 || bready !== 1'b1)
            $display("FAIL raw_at_b got rdy=%b arv=%b bready=%b exp 0 0 1", rd_rdy, arvalid, bready);
        else n_pass++;
        @(posedge clk);
        #1 bvalid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1)
            $display("FAIL raw_release got rd_rdy=%b wr_rdy=%b exp 1 1", rd_rdy, wr_rdy);
        else n_pass++;
        @(posedge clk);
        #1 rd_req = 1'b0;
        ar_phase(32'h0000_3008, 8'd0, 3'd2, 0);
        r_beats(1, $urandom, 0);
    endtask

    task automatic test_reset_mid_burst();
        wr_request(32'h0000_6000, T_WORD, 4'hf, 128'h0);
        rd_request(32'h5000_0044, T_LINE);
        ar_phase(32'h5000_0040, 8'd3, 3'd2, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = 32'(i); rlast = 1'b0;
            @(posedge clk);
            #1 rvalid = 1'b0;
        end
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h2;
        #1;
        n_checks++; if (ret_valid !== 1'b1) $display("FAIL pre_reset_beat got %b exp 1", ret_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ret_valid, rready, arvalid, awvalid, wvalid, bready} !== 6'b0)
            $display("FAIL async_reset_valids got %b exp 000000", {ret_valid, rready, arvalid, awvalid, wvalid, bready});
        else n_pass++;
        @(negedge clk);
        rvalid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1)
            $display("FAIL post_reset_rdy got %b %b exp 1 1", rd_rdy, wr_rdy);
        else n_pass++;
        do_read(32'h5000_0080, T_LINE, 1, 1, $urandom);
    endtask

    task automatic test_random();
        logic [2:0] types [4];
        types = '{T_BYTE, T_HALF, T_WORD, T_LINE};
        for (int k = 0; k < 24; k++) begin
            logic [2:0]  t;
            logic [31:0] a;
            t = types[$urandom_range(3, 0)];
            a = $urandom;
            if ($urandom_range(1, 0) == 0)
                do_read(a, t, int'($urandom_range(3, 0)), 2, $urandom);
            else
                do_write(a, t, 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                         int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 2,
                         int'($urandom_range(3, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_line_read();
        test_word_read();
        test_line_write();
        test_byte_write();
        test_raw_hazard();
        test_reset_mid_burst();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Slave side of the cache-to-memory request interface: accepts dcache refill reads (rd_req/rd_type/rd_addr) and victim or uncached writes (wr_req/wr_type/wr_addr/wr_wstrb/wr_data).
- Converts each request into AXI4 master bursts and returns read beats on ret_valid/ret_last/ret_data.
- Sits between the dcache and the SoC AXI interconnect.
- One outstanding read and one outstanding write, tracked by independent FSMs.

Parameters:
- LINE_BEATS, 4, 32-bit beats per cache line (128-bit line).
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active low.
- rd_req  input  1  read request.
- rd_type  input  3  000 byte, 001 half, 010 word, 100 line.
- rd_addr  input  32  read start address.
- rd_rdy  output  1  read request accepted when rd_req && rd_rdy.
- ret_valid  output  1  read beat valid.
- ret_last  output  1  last beat of the current read.
- ret_data  output  32  read beat data.
- wr_req  input  1  write request.
- wr_type  input  3  encoding as rd_type.
- wr_addr  input  32  write start address.
- wr_wstrb  input  4  byte mask, non-line writes only.
- wr_data  input  128  line data; beat i = wr_data[32i+:32].
- wr_rdy  output  1  write request accepted when wr_req && wr_rdy.
- araddr, awaddr  output  32  AXI addresses.
- arlen, awlen  output  8  burst length minus 1.
- arsize, awsize  output  3  beat size.
- arvalid, awvalid, wvalid, wlast, rready, bready  output  1  AXI handshake/control.
- arready, awready, wready, rvalid, rlast, bvalid  input  1  AXI handshake/control.
- rdata  input  32  AXI read data.
- wdata  output  32  AXI write data.
- wstrb  output  4  AXI write strobe.

Behaviour:
- Reset (rst=0, async):
  - Both FSMs go to idle.
  - All valid/ready outputs = 0, except rd_rdy=1 and wr_rdy=1.
  - Address, len, size and data outputs = 0.
- Read FSM R_IDLE -> R_AR -> R_DATA -> R_IDLE.
  - R_IDLE: rd_rdy = !raw_hazard. On rd_req && rd_rdy, latch addr/type and go to R_AR; rd_rdy drops the next cycle.
  - R_AR: arvalid=1, held stable until arready; then go to R_DATA.
  - arlen = LINE_BEATS-1 for line, else 0. arsize = 2 for line/word, 1 half, 0 byte.
  - Line araddr = {addr[31:4],4'b0}; otherwise araddr = rd_addr unmodified.
  - R_DATA: rready=1. Each rvalid gives ret_valid=1, ret_data=rdata, ret_last=rlast, combinationally the same cycle.
  - On rvalid && rlast, return to R_IDLE. rd_rdy may be 1 the following cycle.
- raw_hazard: write FSM not idle && latched waddr[31:4] == rd_addr[31:4]. The read waits until bvalid && bready completes.
- Write FSM W_IDLE -> W_BUSY -> W_RESP -> W_IDLE.
  - W_IDLE: wr_rdy=1. On wr_req, latch addr/type/wstrb/128-bit data and go to W_BUSY.
  - W_BUSY: AW and W run independently.
  - awvalid=1 until awready, then aw_done flag is set.
  - wvalid=1 with beat counter wcnt (2 bits).
  - Line: wdata = data[32*wcnt+:32], wstrb=4'hf, wlast when wcnt==3.
  - Non-line: single beat, wdata=data[31:0], wstrb=latched wr_wstrb, wlast=1.
  - wcnt increments on wvalid && wready. W may complete before AW and vice versa.
  - When aw_done and the last W beat are both complete (including the same cycle), go to W_RESP.
  - W_RESP: bready=1; bvalid -> W_IDLE. bresp is ignored.
- Read and write FSMs operate concurrently; simultaneous rd_req and wr_req are both accepted in the same cycle.
- Simultaneous acceptance to the same line: the read is accepted first in that cycle. The hazard only blocks new reads once a write is latched.
- Valid outputs never drop before their handshake (AXI rule).
- Reset mid-burst drops everything immediately; no recovery of partial transfers.

Decomposition:
- Shared package (bridge_pkg):
  - Type encodings: TYPE_BYTE=3'b000, TYPE_HALF=3'b001, TYPE_WORD=3'b010, TYPE_LINE=3'b100.
  - Read/write FSM state enums.
  - AXI size constants.
- One natural sub-module: axi_write_channel, which holds the write FSM, beat counter and aw_done logic. The read path stays inline.

Test Plan:
- Line read 0x1C00_0038, rd_type=100: araddr=0x1C00_0030, arlen=3, arsize=2. Four rvalid beats 0xA0..0xA3 appear on ret_data in order; ret_last only with 0xA3; rd_rdy=1 the cycle after.
- Word uncached read 0xBFAF_8004: arlen=0, single ret_valid with ret_last=1. arready delayed 5 cycles keeps arvalid and araddr stable.
- Line write 0x0000_1000, wr_data=0x44..._33..._22..._11...: awlen=3, W beats 0x11..,0x22..,0x33..,0x44.., wstrb=f, wlast on beat 4. awready delayed until after wlast still reaches W_RESP, and wr_rdy returns after bvalid.
- Byte write 0x0000_2003, wr_wstrb=4'b1000: awsize=0, awlen=0, wstrb=1000, single beat wlast=1.
- RAW hazard: line write to 0x3000 pending, bvalid held off, then rd_req to 0x3008 -> rd_rdy=0 and arvalid=0 until the cycle after bvalid&&bready. A read to 0x4000 in the same window is accepted immediately.
- Assert rst low during R_DATA beat 2: all valids 0 asynchronously, rd_rdy=wr_rdy=1 after release, and the next read behaves normally.
